// File: rtl/operand_fetch.sv
// Issue / operand-fetch stage: busy-bit scoreboard with writeback bypass in front of
// a one-entry output register feeding execute.
module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int OPC_WIDTH  = 4,
    parameter int IMM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [OPC_WIDTH-1:0]  inOpcode,
    input  logic [ADDR_WIDTH-1:0] inSrc1,
    input  logic [ADDR_WIDTH-1:0] inSrc2,
    input  logic [ADDR_WIDTH-1:0] inDest,
    input  logic                  inUsesSrc2,
    input  logic                  inWritesDest,
    input  logic [IMM_WIDTH-1:0]  inImm,
    output logic [ADDR_WIDTH-1:0] readAddr1,
    output logic [ADDR_WIDTH-1:0] readAddr2,
    input  logic [DATA_WIDTH-1:0] readData1,
    input  logic [DATA_WIDTH-1:0] readData2,
    input  logic                  wbValid,
    input  logic [ADDR_WIDTH-1:0] wbAddr,
    input  logic [DATA_WIDTH-1:0] wbData,
    input  logic                  flush,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [OPC_WIDTH-1:0]  outOpcode,
    output logic [DATA_WIDTH-1:0] outOperand1,
    output logic [DATA_WIDTH-1:0] outOperand2,
    output logic [IMM_WIDTH-1:0]  outImm,
    output logic [ADDR_WIDTH-1:0] outDest,
    output logic                  outWritesDest
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0]   busyReg;
    logic [NUM_REGS-1:0]   busyNext;
    logic [NUM_REGS-1:0]   wbHit;
    logic [NUM_REGS-1:0]   effBusy;
    logic [NUM_REGS-1:0]   setHit;
    logic [NUM_REGS-1:0]   flushHit;

    logic                  outValidReg;
    logic [OPC_WIDTH-1:0]  outOpcodeReg;
    logic [DATA_WIDTH-1:0] outOperand1Reg;
    logic [DATA_WIDTH-1:0] outOperand2Reg;
    logic [IMM_WIDTH-1:0]  outImmReg;
    logic [ADDR_WIDTH-1:0] outDestReg;
    logic                  outWritesDestReg;

    logic                  hazard;
    logic                  accept;
    logic                  flushKill;
    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;

    assign readAddr1 = inSrc1;
    assign readAddr2 = inSrc2;

    // A flushed writer never reaches writeback, so its reservation is released here.
    assign flushKill = flush && outValidReg && outWritesDestReg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : gRegs
            assign wbHit[gi]    = wbValid && (wbAddr == ADDR_WIDTH'(gi));
            assign effBusy[gi]  = busyReg[gi] && !wbHit[gi];
            assign setHit[gi]   = accept && inWritesDest && (inDest == ADDR_WIDTH'(gi));
            assign flushHit[gi] = flushKill && (outDestReg == ADDR_WIDTH'(gi));
            // A new reservation beats a same-cycle release of the previous owner.
            assign busyNext[gi] = setHit[gi] | (busyReg[gi] & ~wbHit[gi] & ~flushHit[gi]);
        end
    endgenerate

    assign hazard = inValid && (effBusy[inSrc1]
                             || (inUsesSrc2 && effBusy[inSrc2])
                             || (inWritesDest && effBusy[inDest]));

    assign inReady = !reset && !flush && !hazard && (!outValidReg || outReady);
    assign accept  = inValid && inReady;

    assign operand1 = wbHit[inSrc1] ? wbData : readData1;
    assign operand2 = !inUsesSrc2    ? '0     :
                      wbHit[inSrc2]  ? wbData : readData2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busyReg <= '0;
        end else begin
            busyReg <= busyNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValidReg      <= 1'b0;
            outOpcodeReg     <= '0;
            outOperand1Reg   <= '0;
            outOperand2Reg   <= '0;
            outImmReg        <= '0;
            outDestReg       <= '0;
            outWritesDestReg <= 1'b0;
        end else if (flush) begin
            outValidReg <= 1'b0;
        end else if (accept) begin
            outValidReg      <= 1'b1;
            outOpcodeReg     <= inOpcode;
            outOperand1Reg   <= operand1;
            outOperand2Reg   <= operand2;
            outImmReg        <= inImm;
            outDestReg       <= inDest;
            outWritesDestReg <= inWritesDest;
        end else if (outValidReg && outReady) begin
            outValidReg <= 1'b0;
        end
    end

    assign outValid      = outValidReg;
    assign outOpcode     = outOpcodeReg;
    assign outOperand1   = outOperand1Reg;
    assign outOperand2   = outOperand2Reg;
    assign outImm        = outImmReg;
    assign outDest       = outDestReg;
    assign outWritesDest = outWritesDestReg;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model, vector table for plain issue and
// hand sequences for RAW, WAW, backpressure, flush and asynchronous reset.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [3:0]  inOpcode;
    logic [2:0]  inSrc1, inSrc2, inDest;
    logic        inUsesSrc2, inWritesDest;
    logic [15:0] inImm;
    logic [2:0]  readAddr1, readAddr2;
    logic [31:0] readData1, readData2;
    logic        wbValid;
    logic [2:0]  wbAddr;
    logic [31:0] wbData;
    logic        flush;
    logic        outValid, outReady;
    logic [3:0]  outOpcode;
    logic [31:0] outOperand1, outOperand2;
    logic [15:0] outImm;
    logic [2:0]  outDest;
    logic        outWritesDest;

    logic [31:0] rf [8];

    typedef struct {
        logic [3:0]  opc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [15:0] imm;
        logic [2:0]  dest;
        logic        wd;
    } sb_t;

    typedef struct {
        logic [3:0]  opc;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic        uses;
        logic [15:0] imm;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    sb_t  sbQ [$];
    vec_t vecs [6];
    int   totalCnt = 0;
    int   badCnt   = 0;

    operand_fetch dut (
        .clk(clk), .reset(reset),
        .inValid(inValid), .inReady(inReady), .inOpcode(inOpcode),
        .inSrc1(inSrc1), .inSrc2(inSrc2), .inDest(inDest),
        .inUsesSrc2(inUsesSrc2), .inWritesDest(inWritesDest), .inImm(inImm),
        .readAddr1(readAddr1), .readAddr2(readAddr2),
        .readData1(readData1), .readData2(readData2),
        .wbValid(wbValid), .wbAddr(wbAddr), .wbData(wbData),
        .flush(flush), .outValid(outValid), .outReady(outReady),
        .outOpcode(outOpcode), .outOperand1(outOperand1), .outOperand2(outOperand2),
        .outImm(outImm), .outDest(outDest), .outWritesDest(outWritesDest)
    );

    assign readData1 = rf[readAddr1];
    assign readData2 = rf[readAddr2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act !== exp) begin
            badCnt++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelOp(input logic [2:0] a);
        return (wbValid && wbAddr == a) ? wbData : rf[a];
    endfunction

    task automatic preload();
        for (int i = 0; i < 8; i++) rf[i] = 32'((i + 1) * 10);
    endtask

    task automatic drive(input logic [3:0] opc, input logic [2:0] s1, input logic [2:0] s2,
                         input logic u, input logic [2:0] d, input logic w, input logic [15:0] imm);
        inValid = 1'b1; inOpcode = opc; inSrc1 = s1; inSrc2 = s2;
        inUsesSrc2 = u; inDest = d; inWritesDest = w; inImm = imm;
    endtask

    task automatic idle();
        inValid = 1'b0;
    endtask

    // Called at posedge+1; samples at posedge+4, then advances one cycle.
    task automatic tick(input bit chkReady, input bit expReady, input bit useExp,
                        input logic [31:0] e1, input logic [31:0] e2);
        sb_t ent, got;
        logic doWb;
        logic [2:0] wa;
        logic [31:0] wd;
        #3;
        if (chkReady) check("inReady", 64'(inReady), 64'(expReady));
        if (flush && outValid) begin
            if (sbQ.size() > 0) got = sbQ.pop_front();
            $display("flush drops held opc=%0d", outOpcode);
        end else if (outValid && outReady) begin
            if (sbQ.size() == 0) begin
                totalCnt++; badCnt++;
                $display("FAIL unexpectedOut: got outValid=1 want no pending instruction");
            end else begin
                got = sbQ.pop_front();
                check("outOpcode", 64'(outOpcode), 64'(got.opc));
                check("outOperand1", 64'(outOperand1), 64'(got.op1));
                check("outOperand2", 64'(outOperand2), 64'(got.op2));
                check("outImm", 64'(outImm), 64'(got.imm));
                check("outDest", 64'(outDest), 64'(got.dest));
                check("outWritesDest", 64'(outWritesDest), 64'(got.wd));
                $display("out opc=%0d op1=%0d op2=%0d imm=%0h dest=%0d wd=%0d",
                         outOpcode, outOperand1, outOperand2, outImm, outDest, outWritesDest);
            end
        end
        if (inValid && inReady) begin
            ent.opc  = inOpcode;
            ent.op1  = useExp ? e1 : modelOp(inSrc1);
            ent.op2  = useExp ? e2 : (inUsesSrc2 ? modelOp(inSrc2) : 32'd0);
            ent.imm  = inImm;
            ent.dest = inDest;
            ent.wd   = inWritesDest;
            sbQ.push_back(ent);
            $display("issue opc=%0d src1=%0d src2=%0d dest=%0d", inOpcode, inSrc1, inSrc2, inDest);
        end
        doWb = wbValid; wa = wbAddr; wd = wbData;
        @(posedge clk);
        #1;
        if (doWb) rf[wa] = wd;
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; inOpcode = '0; inSrc1 = '0; inSrc2 = '0;
        inDest = '0; inUsesSrc2 = 1'b0; inWritesDest = 1'b0; inImm = '0;
        wbValid = 1'b0; wbAddr = '0; wbData = '0; flush = 1'b0; outReady = 1'b1;
        preload();

        vecs[0] = '{4'd1, 3'd3, 3'd2, 1'b1, 16'h1111, 32'd40, 32'd30};
        vecs[1] = '{4'd2, 3'd0, 3'd7, 1'b1, 16'h2222, 32'd10, 32'd80};
        vecs[2] = '{4'd3, 3'd6, 3'd1, 1'b0, 16'h3333, 32'd70, 32'd0};
        vecs[3] = '{4'd4, 3'd1, 3'd1, 1'b1, 16'h4444, 32'd20, 32'd20};
        vecs[4] = '{4'd5, 3'd7, 3'd5, 1'b1, 16'h5555, 32'd80, 32'd60};
        vecs[5] = '{4'd6, 3'd4, 3'd4, 1'b0, 16'h6666, 32'd50, 32'd0};

        @(posedge clk); #1;
        check("resetOutValid", 64'(outValid), 64'd0);
        check("resetInReady", 64'(inReady), 64'd0);
        check("resetOperand1", 64'(outOperand1), 64'd0);
        check("resetBusy", 64'(dut.busyReg), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Plain issue at full throughput.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].opc, vecs[i].s1, vecs[i].s2, vecs[i].uses, 3'd0, 1'b0, vecs[i].imm);
            tick(1, 1, 1, vecs[i].e1, vecs[i].e2);
            check("readAddr1", 64'(readAddr1), 64'(vecs[i].s1));
            check("outValidLatency", 64'(outValid), 64'd1);
        end
        idle();
        tick(0, 0, 0, 0, 0);
        check("drained", 64'(sbQ.size()), 64'd0);

        // RAW: consumer stalls until writeback, then gets bypassed data.
        drive(4'd7, 3'd0, 3'd0, 1'b0, 3'd5, 1'b1, 16'h0007);
        tick(1, 1, 0, 0, 0);
        drive(4'd8, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0008);
        for (int i = 0; i < 2; i++) begin
            tick(1, 0, 0, 0, 0);
            check("rawBusy5", 64'(dut.busyReg[5]), 64'd1);
        end
        wbValid = 1'b1; wbAddr = 3'd5; wbData = 32'd100;
        tick(1, 1, 1, 32'd100, 32'd0);
        wbValid = 1'b0;
        idle();
        tick(0, 0, 0, 0, 0);
        check("rawBusy5Clear", 64'(dut.busyReg[5]), 64'd0);

        // WAW: second writer waits for first writeback; set wins over clear.
        drive(4'd9, 3'd0, 3'd0, 1'b0, 3'd4, 1'b1, 16'h0009);
        tick(1, 1, 0, 0, 0);
        drive(4'd10, 3'd1, 3'd0, 1'b0, 3'd4, 1'b1, 16'h000a);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        wbValid = 1'b1; wbAddr = 3'd4; wbData = 32'd55;
        tick(1, 1, 0, 0, 0);
        wbValid = 1'b0;
        check("wawBusy4", 64'(dut.busyReg[4]), 64'd1);
        idle();
        wbValid = 1'b1; wbAddr = 3'd4; wbData = 32'd66;
        tick(0, 0, 0, 0, 0);
        wbValid = 1'b0;
        check("wawBusy4Clear", 64'(dut.busyReg[4]), 64'd0);

        // Backpressure: held output stays put, next instruction enters when released.
        drive(4'd11, 3'd2, 3'd0, 1'b0, 3'd0, 1'b0, 16'h000b);
        tick(1, 1, 0, 0, 0);
        drive(4'd12, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 16'h000c);
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0, 0);
            check("bpOutValid", 64'(outValid), 64'd1);
            check("bpOperand1", 64'(outOperand1), 64'd30);
            check("bpOpcode", 64'(outOpcode), 64'd11);
        end
        outReady = 1'b1;
        tick(1, 1, 1, 32'd20, 32'd0);
        idle();
        tick(0, 0, 0, 0, 0);

        // Flush of a held writer releases its destination.
        outReady = 1'b0;
        drive(4'd13, 3'd0, 3'd0, 1'b0, 3'd6, 1'b1, 16'h000d);
        tick(1, 1, 0, 0, 0);
        idle();
        flush = 1'b1;
        tick(1, 0, 0, 0, 0);
        flush = 1'b0;
        check("flushOutValid", 64'(outValid), 64'd0);
        check("flushBusy6", 64'(dut.busyReg[6]), 64'd0);
        outReady = 1'b1;
        drive(4'd14, 3'd6, 3'd0, 1'b0, 3'd0, 1'b0, 16'h000e);
        tick(1, 1, 1, 32'd70, 32'd0);
        idle();
        tick(0, 0, 0, 0, 0);

        // Asynchronous reset while a writer is held and reserved.
        outReady = 1'b0;
        drive(4'd15, 3'd0, 3'd0, 1'b0, 3'd5, 1'b1, 16'h000f);
        tick(1, 1, 0, 0, 0);
        idle();
        check("preResetOutValid", 64'(outValid), 64'd1);
        check("preResetBusy5", 64'(dut.busyReg[5]), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("asyncOutValid", 64'(outValid), 64'd0);
        check("asyncBusy", 64'(dut.busyReg), 64'd0);
        check("asyncInReady", 64'(inReady), 64'd0);
        check("asyncOpcode", 64'(outOpcode), 64'd0);
        sbQ.delete();
        preload();
        @(posedge clk); #1;
        reset = 1'b0;
        outReady = 1'b1;
        drive(4'd3, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0003);
        tick(1, 1, 1, 32'd60, 32'd0);
        idle();
        tick(0, 0, 0, 0, 0);
        check("finalDrained", 64'(sbQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue/operand-fetch stage that sits directly upstream of `RegisterFile`. It accepts one decoded instruction per cycle over a valid/ready handshake and drives the register-file read addresses. It resolves read-after-write and write-after-write hazards with a per-register busy scoreboard, bypassing same-cycle writeback data. It then presents the instruction and its operands to the execute stage through a one-entry output register.

## Interface
- `DATA_WIDTH`, 32, register/operand width
- `ADDR_WIDTH`, 3, register address width (8 registers, all general purpose, none hardwired)
- `OPC_WIDTH`, 4, opcode width
- `IMM_WIDTH`, 16, immediate width, passed through unmodified

- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high
- `inValid`  in  1  upstream instruction valid
- `inReady`  out  1  stage accepts instruction this cycle
- `inOpcode`  in  OPC_WIDTH  opcode
- `inSrc1`, `inSrc2`, `inDest`  in  ADDR_WIDTH  source/destination register numbers
- `inUsesSrc2`  in  1  instruction reads src2
- `inWritesDest`  in  1  instruction writes dest
- `inImm`  in  IMM_WIDTH  immediate
- `readAddr1`, `readAddr2`  out  ADDR_WIDTH  to RegisterFile read ports
- `readData1`, `readData2`  in  DATA_WIDTH  from RegisterFile (combinational read)
- `wbValid`  in  1  writeback this cycle (same signal drives RegisterFile `writeEnable`)
- `wbAddr`  in  ADDR_WIDTH  writeback register
- `wbData`  in  DATA_WIDTH  writeback data
- `flush`  in  1  kill instruction held in output register
- `outValid`  out  1  output instruction valid
- `outReady`  in  1  execute stage consumes output
- `outOpcode`  out  OPC_WIDTH
- `outOperand1`, `outOperand2`  out  DATA_WIDTH
- `outImm`  out  IMM_WIDTH
- `outDest`  out  ADDR_WIDTH
- `outWritesDest`  out  1

## Operation
- `readAddr1 = inSrc1`, `readAddr2 = inSrc2`, combinational at all times.
- Scoreboard: `busy[2**ADDR_WIDTH]`, one bit per register. A set bit means a write to that register is outstanding.
- `clr(r) = wbValid && wbAddr == r`. The effective busy value is `busy[r] && !clr(r)`.
- Hazard when `inValid` and any of the following:
  - src1 is effectively busy;
  - `inUsesSrc2` and src2 is effectively busy;
  - `inWritesDest` and dest is effectively busy (WAW).
- The WAW stall guarantees at most one outstanding write per register.
- Operand mux: operand1 = `wbData` if `clr(inSrc1)`, else `readData1`.
- Operand2 uses the same rule on src2, and is forced to 0 when `!inUsesSrc2`.
- `inReady = !reset && !flush && !hazard && (!outValid || outReady)`.
- Accept = `inValid && inReady`. On accept:
  - output register loads opcode, operands, imm, dest, writesDest;
  - `outValid` becomes 1;
  - if `inWritesDest`, `busy[inDest]` is set.
- When `outValid && outReady` and there is no accept, `outValid` becomes 0. The data fields hold their last values.
- Writeback clears `busy[wbAddr]`. If `wbValid` targets a register whose busy bit is clear, it is ignored.
- If set and clear hit the same register in one cycle, set wins (new owner).
- Flush:
  - `outValid` becomes 0;
  - if `outValid && outWritesDest`, `busy[outDest]` is cleared;
  - no accept occurs that cycle (`inReady` = 0);
  - writebacks are still processed.
- `outReady` is ignored when `outValid` = 0.

## Timing
- Reset (asynchronous, immediate): `outValid` = 0, all out data fields = 0, all busy bits = 0. `inReady` = 0 while `reset` is high.
- Reset mid-operation drops the held instruction and all scoreboard state.
- Latency: accept in cycle N gives `outValid` = 1 with operands in cycle N+1.
- Throughput: 1 instruction/cycle when there is no hazard and `outReady` = 1.
- A dependent instruction stalls from the cycle after its producer is accepted until the cycle its writeback is presented. In the writeback cycle it is accepted with `wbData` bypassed.
- `outValid` and the out fields are registered only. `inReady` depends combinationally on `outValid`, `outReady`, `flush`, `wbValid`/`wbAddr` and the in fields.
- The output register holds stable while `outValid && !outReady`.

## Test plan
- Register file preloaded with 10,20,…,80 in regs 0–7:
  - Stimulus: issue src1=3, src2=2, usesSrc2=1.
  - Required: next cycle `outValid`=1, operand1=40, operand2=30.
- Back-to-back issue with `outReady`=1:
  - Stimulus: producer dest=5, then consumer src1=5.
  - Required: consumer held (`inReady`=0) while `busy[5]`=1. In the cycle `wbValid`=1, `wbAddr`=5, `wbData`=100, the consumer is accepted and `outOperand1`=100.
- WAW:
  - Stimulus: two writers to dest=4.
  - Required: the second stalls until the first's writeback, then `busy[4]` stays 1 (set wins).
- Backpressure:
  - Stimulus: `outReady`=0 for 3 cycles with `outValid`=1.
  - Required: out fields stable, `inReady`=0. Once `outReady`=1, the next instruction is accepted in that same cycle.
- Flush:
  - Stimulus: `flush` with held dest=6 writer.
  - Required: `outValid`=0 next cycle, `busy[6]`=0, and an instruction reading reg 6 is accepted without a stall.
- Reset mid-stall:
  - Stimulus: assert `reset` asynchronously while `busy[5]`=1 and `outValid`=1.
  - Required: `outValid`=0 and all busy bits 0 before the next edge. After release, src1=5 issues with no stall, reading 60.
